// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - UART-fed program image loader for instruction memory
//
// Parses SYNC, LEN_LO, LEN_HI, 4*LEN little-endian payload bytes and a mod-256
// checksum byte. It writes each assembled word into instruction memory and
// keeps the CPU held until a frame with a correct checksum has been received.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   rx_data      received byte from the UART
//   rx_valid     one-cycle strobe, rx_data holds a new byte
//   imem_we      instruction memory write strobe (one-cycle pulse per word)
//   imem_addr    instruction memory word address
//   imem_wdata   instruction word to write
//   cpu_hold     holds the CPU fetch unit; low only once the image is accepted
//   boot_done    image accepted, CPU running
//   boot_error   frame rejected (bad length, bad checksum or timeout)
//   words_loaded number of words written in the current frame

module uart_boot_loader #(
  parameter int          IMEM_WORDS     = 256,
  parameter int          ADDR_W         = 8,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              boot_done,
  output logic              boot_error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        csum_q, csum_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   words_loaded_q, words_loaded_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  logic [15:0]       len_in;
  logic [TMO_W-1:0]  tmo_inc;
  logic              tmo_active;
  logic              last_word;
  logic [31:0]       word_shift;

  assign len_in     = {rx_data, len_q[7:0]};
  assign tmo_inc    = tmo_q + 1'b1;
  assign tmo_active = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                      (state_q == S_DATA)   || (state_q == S_CSUM);
  // True while the word now being assembled is the final one of the frame.
  assign last_word  = (16'(words_loaded_q) + 16'd1) == len_q;
  // Little-endian lane fill: after four shifts, the first byte sits in [7:0].
  assign word_shift = {rx_data, word_q[31:8]};

  // State register and datapath flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      len_q          <= '0;
      byte_idx_q     <= '0;
      word_q         <= '0;
      csum_q         <= '0;
      addr_q         <= '0;
      words_loaded_q <= '0;
      imem_we_q      <= 1'b0;
      imem_addr_q    <= '0;
      imem_wdata_q   <= '0;
      tmo_q          <= '0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      byte_idx_q     <= byte_idx_d;
      word_q         <= word_d;
      csum_q         <= csum_d;
      addr_q         <= addr_d;
      words_loaded_q <= words_loaded_d;
      imem_we_q      <= imem_we_d;
      imem_addr_q    <= imem_addr_d;
      imem_wdata_q   <= imem_wdata_d;
      tmo_q          <= tmo_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (rx_valid) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (rx_valid) begin
          if (len_in > 16'(IMEM_WORDS)) state_d = S_ERROR;
          else if (len_in == 16'd0)     state_d = S_CSUM;
          else                          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (rx_valid && byte_idx_q == 2'd3 && last_word) state_d = S_CSUM;
      end
      S_CSUM: begin
        if (rx_valid) state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      S_ERROR: begin
        // A fresh SYNC is treated as a retry of the whole frame.
        if (rx_valid && rx_data == SYNC_BYTE) state_d = S_LEN_LO;
      end
      default: state_d = S_IDLE;
    endcase
    // Inter-byte silence inside a frame aborts it.
    if (tmo_active && !rx_valid && tmo_inc == TMO_W'(TIMEOUT_CYCLES)) begin
      state_d = S_ERROR;
    end
  end

  // Datapath next values
  always_comb begin
    len_d          = len_q;
    byte_idx_d     = byte_idx_q;
    word_d         = word_q;
    csum_d         = csum_q;
    addr_d         = addr_q;
    words_loaded_d = words_loaded_q;
    imem_we_d      = 1'b0;
    imem_addr_d    = imem_addr_q;
    imem_wdata_d   = imem_wdata_q;
    tmo_d          = (tmo_active && !rx_valid) ? tmo_inc : '0;

    if (rx_valid) begin
      case (state_q)
        S_LEN_LO: begin
          len_d[7:0] = rx_data;
        end
        S_LEN_HI: begin
          len_d[15:8]    = rx_data;
          byte_idx_d     = '0;
          word_d         = '0;
          csum_d         = '0;
          addr_d         = '0;
          imem_addr_d    = '0;
          words_loaded_d = '0;
        end
        S_DATA: begin
          word_d     = word_shift;
          csum_d     = csum_q + rx_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            imem_we_d      = 1'b1;
            imem_addr_d    = addr_q;
            imem_wdata_d   = word_shift;
            addr_d         = addr_q + 1'b1;
            words_loaded_d = words_loaded_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    cpu_hold     = (state_q != S_DONE);
    boot_done    = (state_q == S_DONE);
    boot_error   = (state_q == S_ERROR);
    imem_we      = imem_we_q;
    imem_addr    = imem_addr_q;
    imem_wdata   = imem_wdata_q;
    words_loaded = words_loaded_q;
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb/tb_uart_boot_loader.sv - self-checking bench for uart_boot_loader

module tb_uart_boot_loader;

  localparam int         IMEM_WORDS = 256;
  localparam int         ADDR_W     = 8;
  localparam logic [7:0] SYNC       = 8'hA5;
  localparam int         TMO        = 50;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              boot_done;
  logic              boot_error;
  logic [ADDR_W:0]   words_loaded;

  uart_boot_loader #(
    .IMEM_WORDS     (IMEM_WORDS),
    .ADDR_W         (ADDR_W),
    .SYNC_BYTE      (SYNC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_hold     (cpu_hold),
    .boot_done    (boot_done),
    .boot_error   (boot_error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]        payload[$];
  logic [7:0]        frame_q[$];
  logic [31:0]       exp_data[$];
  logic [ADDR_W-1:0] got_addr[$];
  logic [31:0]       got_data[$];

  // Every write strobe seen on the memory port, in order.
  always @(negedge clk) begin
    if (imem_we) begin
      got_addr.push_back(imem_addr);
      got_data.push_back(imem_wdata);
    end
  end

  // Called at a negedge; returns at a negedge, gap idle clocks after the byte.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = $urandom_range(255, 0);
    repeat (gap) @(negedge clk);
  endtask

  // Sends frame_q; the last byte is sent with no trailing gap.
  task automatic send_frame(input int max_gap, input int skip_last);
    for (int i = 0; i < frame_q.size() - skip_last; i++) begin
      send_byte(frame_q[i], (i == frame_q.size() - 1) ? 0 : $urandom_range(max_gap, 0));
    end
  endtask

  // Reference model: frame bytes and expected words from payload.
  task automatic build_frame(input int len, input bit good_csum);
    int sum;
    logic [7:0] cs;
    frame_q.delete();
    exp_data.delete();
    sum = 0;
    frame_q.push_back(SYNC);
    frame_q.push_back(len % 256);
    frame_q.push_back(len / 256);
    foreach (payload[i]) begin
      frame_q.push_back(payload[i]);
      sum += payload[i];
    end
    for (int w = 0; w < payload.size() / 4; w++) begin
      exp_data.push_back(payload[4*w] + (payload[4*w+1] * 256) +
                         (payload[4*w+2] * 65536) + (payload[4*w+3] * 16777216));
    end
    cs = sum % 256;
    if (!good_csum) cs = cs ^ 8'($urandom_range(255, 1));
    frame_q.push_back(cs);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    got_addr.delete();
    got_data.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    do_reset();
    checks += 7;
    if (imem_we !== 1'b0)      begin errors++; $display("FAIL reset_we got %b want 0", imem_we); end
    if (imem_addr !== '0)      begin errors++; $display("FAIL reset_addr got %h want 0", imem_addr); end
    if (imem_wdata !== 32'h0)  begin errors++; $display("FAIL reset_wdata got %h want 0", imem_wdata); end
    if (words_loaded !== '0)   begin errors++; $display("FAIL reset_words got %0d want 0", words_loaded); end
    if (cpu_hold !== 1'b1)     begin errors++; $display("FAIL reset_hold got %b want 1", cpu_hold); end
    if (boot_done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b want 0", boot_done); end
    if (boot_error !== 1'b0)   begin errors++; $display("FAIL reset_error got %b want 0", boot_error); end
  endtask

  task automatic test_good_image();
    do_reset();
    payload = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    build_frame(2, 1'b1);
    send_frame(2, 1);
    checks += 2;
    if (boot_done !== 1'b0) begin errors++; $display("FAIL good_done_early got %b want 0", boot_done); end
    if (cpu_hold !== 1'b1)  begin errors++; $display("FAIL good_hold_early got %b want 1", cpu_hold); end
    send_byte(8'hB6, 0);
    checks += 4;
    if (boot_done !== 1'b1)     begin errors++; $display("FAIL good_done got %b want 1", boot_done); end
    if (cpu_hold !== 1'b0)      begin errors++; $display("FAIL good_hold got %b want 0", cpu_hold); end
    if (boot_error !== 1'b0)    begin errors++; $display("FAIL good_error got %b want 0", boot_error); end
    if (words_loaded !== 9'd2)  begin errors++; $display("FAIL good_words got %0d want 2", words_loaded); end
    checks++;
    if (got_data.size() !== 2) begin
      errors++; $display("FAIL good_nwrites got %0d want 2", got_data.size());
    end else begin
      checks += 4;
      if (got_addr[0] !== 8'd0)          begin errors++; $display("FAIL good_addr0 got %0d want 0", got_addr[0]); end
      if (got_data[0] !== 32'h00000013)  begin errors++; $display("FAIL good_data0 got %h want 00000013", got_data[0]); end
      if (got_addr[1] !== 8'd1)          begin errors++; $display("FAIL good_addr1 got %0d want 1", got_addr[1]); end
      if (got_data[1] !== 32'h00100093)  begin errors++; $display("FAIL good_data1 got %h want 00100093", got_data[1]); end
    end
  endtask

  task automatic test_bad_csum_retry();
    do_reset();
    payload = '{8'h01, 8'h02, 8'h03, 8'h04};
    build_frame(1, 1'b1);
    frame_q[frame_q.size() - 1] = 8'h00;
    send_frame(1, 0);
    repeat (2) @(negedge clk);
    checks += 4;
    if (boot_error !== 1'b1)     begin errors++; $display("FAIL badcs_error got %b want 1", boot_error); end
    if (cpu_hold !== 1'b1)       begin errors++; $display("FAIL badcs_hold got %b want 1", cpu_hold); end
    if (got_data.size() !== 1)   begin errors++; $display("FAIL badcs_nwrites got %0d want 1", got_data.size()); end
    else if (got_data[0] !== 32'h04030201) begin errors++; $display("FAIL badcs_data got %h want 04030201", got_data[0]); end
    if (boot_done !== 1'b0)      begin errors++; $display("FAIL badcs_done got %b want 0", boot_done); end
    frame_q[frame_q.size() - 1] = 8'h0A;
    send_frame(1, 0);
    checks += 4;
    if (boot_error !== 1'b0)   begin errors++; $display("FAIL retry_error got %b want 0", boot_error); end
    if (boot_done !== 1'b1)    begin errors++; $display("FAIL retry_done got %b want 1", boot_done); end
    if (cpu_hold !== 1'b0)     begin errors++; $display("FAIL retry_hold got %b want 0", cpu_hold); end
    if (got_data.size() !== 2) begin errors++; $display("FAIL retry_nwrites got %0d want 2", got_data.size()); end
  endtask

  task automatic test_oversize();
    do_reset();
    send_byte(SYNC, 0);
    send_byte(8'h01, 1);
    send_byte(8'h01, 0);
    checks++;
    if (boot_error !== 1'b1) begin errors++; $display("FAIL oversize_error got %b want 1", boot_error); end
    repeat (4) send_byte(8'h55, 0);
    repeat (2) @(negedge clk);
    checks += 2;
    if (got_data.size() !== 0) begin errors++; $display("FAIL oversize_nwrites got %0d want 0", got_data.size()); end
    if (cpu_hold !== 1'b1)     begin errors++; $display("FAIL oversize_hold got %b want 1", cpu_hold); end
  endtask

  task automatic test_zero_len_noise();
    do_reset();
    send_byte(8'h00, 1);
    send_byte(8'hFF, 0);
    checks++;
    if (boot_error !== 1'b0 || boot_done !== 1'b0) begin
      errors++; $display("FAIL noise_flags got done=%b err=%b want 0 0", boot_done, boot_error);
    end
    payload.delete();
    build_frame(0, 1'b1);
    send_frame(0, 0);
    checks += 3;
    if (boot_done !== 1'b1)    begin errors++; $display("FAIL zero_done got %b want 1", boot_done); end
    if (words_loaded !== '0)   begin errors++; $display("FAIL zero_words got %0d want 0", words_loaded); end
    if (got_data.size() !== 0) begin errors++; $display("FAIL zero_nwrites got %0d want 0", got_data.size()); end
  endtask

  task automatic test_timeout();
    do_reset();
    send_byte(SYNC, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    repeat (TMO - 1) @(negedge clk);
    checks++;
    if (boot_error !== 1'b0) begin errors++; $display("FAIL timeout_early got %b want 0", boot_error); end
    @(negedge clk);
    checks += 3;
    if (boot_error !== 1'b1)   begin errors++; $display("FAIL timeout_error got %b want 1", boot_error); end
    if (cpu_hold !== 1'b1)     begin errors++; $display("FAIL timeout_hold got %b want 1", cpu_hold); end
    if (got_data.size() !== 0) begin errors++; $display("FAIL timeout_nwrites got %0d want 0", got_data.size()); end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    do_reset();
    send_byte(SYNC, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst = 1'b1;
    @(negedge clk);
    checks += 4;
    if (cpu_hold !== 1'b1 || boot_done !== 1'b0 || boot_error !== 1'b0) begin
      errors++; $display("FAIL midrst_flags got hold=%b done=%b err=%b want 1 0 0", cpu_hold, boot_done, boot_error);
    end
    if (imem_we !== 1'b0)     begin errors++; $display("FAIL midrst_we got %b want 0", imem_we); end
    if (words_loaded !== '0)  begin errors++; $display("FAIL midrst_words got %0d want 0", words_loaded); end
    if (imem_addr !== '0 || imem_wdata !== '0) begin
      errors++; $display("FAIL midrst_port got %h/%h want 0/0", imem_addr, imem_wdata);
    end
    rst = 1'b0;
    // The remaining bytes of the abandoned word must not complete it.
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    payload.delete();
    repeat (12) payload.push_back($urandom_range(255, 0));
    build_frame(3, 1'b1);
    send_frame(2, 0);
    checks += 2;
    if (boot_done !== 1'b1)    begin errors++; $display("FAIL midrst_done got %b want 1", boot_done); end
    if (got_data.size() !== 3) begin errors++; $display("FAIL midrst_nwrites got %0d want 3", got_data.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_data[i] !== exp_data[i] || got_addr[i] !== 8'(i)) begin
          errors++; $display("FAIL midrst_word%0d got %0d:%h want %0d:%h", i, got_addr[i], got_data[i], i, exp_data[i]);
        end
      end
    end
    n = got_data.size();
    send_byte(SYNC, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    repeat (4) send_byte(8'h77, 0);
    send_byte(8'hDC, 0);
    repeat (3) @(negedge clk);
    checks += 2;
    if (got_data.size() !== n) begin errors++; $display("FAIL postdone_nwrites got %0d want %0d", got_data.size(), n); end
    if (boot_done !== 1'b1 || cpu_hold !== 1'b0) begin
      errors++; $display("FAIL postdone_flags got done=%b hold=%b want 1 0", boot_done, cpu_hold);
    end
  endtask

  task automatic test_random_frames();
    int len;
    bit good;
    logic [7:0] b;
    for (int it = 0; it < 8; it++) begin
      do_reset();
      repeat ($urandom_range(3, 0)) begin
        b = $urandom_range(255, 0);
        if (b == SYNC) b = 8'h00;
        send_byte(b, $urandom_range(2, 0));
      end
      len  = $urandom_range(8, 1);
      good = (it == 0) ? 1'b1 : 1'($urandom_range(1, 0));
      payload.delete();
      repeat (4 * len) payload.push_back($urandom_range(255, 0));
      build_frame(len, good);
      send_frame((it == 0) ? 0 : 3, 0);
      @(negedge clk);
      checks += 4;
      if (boot_done !== good)     begin errors++; $display("FAIL rand%0d_done got %b want %b", it, boot_done, good); end
      if (boot_error !== !good)   begin errors++; $display("FAIL rand%0d_error got %b want %b", it, boot_error, !good); end
      if (cpu_hold !== !good)     begin errors++; $display("FAIL rand%0d_hold got %b want %b", it, cpu_hold, !good); end
      if (words_loaded !== 9'(len)) begin errors++; $display("FAIL rand%0d_words got %0d want %0d", it, words_loaded, len); end
      checks++;
      if (got_data.size() !== len) begin
        errors++; $display("FAIL rand%0d_nwrites got %0d want %0d", it, got_data.size(), len);
      end else begin
        for (int i = 0; i < len; i++) begin
          checks++;
          if (got_data[i] !== exp_data[i] || got_addr[i] !== 8'(i)) begin
            errors++; $display("FAIL rand%0d_word%0d got %0d:%h want %0d:%h", it, i, got_addr[i], got_data[i], i, exp_data[i]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_image();
    test_bad_csum_retry();
    test_oversize();
    test_zero_len_noise();
    test_timeout();
    test_reset_mid_frame();
    test_random_frames();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Sits between the UART receiver and the CPU instruction memory. Consumes received bytes and writes a program image into instruction memory while holding the CPU.
- On a valid image it releases the CPU. The CPU then starts fetching from word 0.
- Replaces hard-coded program loading. Drives the instruction-memory write port and the fetch hang input.

Parameters:
IMEM_WORDS, 256, instruction memory depth in 32-bit words
ADDR_W, 8, word-address width; must satisfy 2**ADDR_W >= IMEM_WORDS
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYCLES, 1000000, maximum idle clocks between bytes inside a frame

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
rx_data  input  8  received byte from UART (UDRR)
rx_valid  input  1  one-cycle pulse: rx_data holds a new byte
imem_we  output  1  instruction memory write strobe
imem_addr  output  ADDR_W  instruction memory word address
imem_wdata  output  32  instruction word to write
cpu_hold  output  1  holds the CPU; connected to the fetch hang input
boot_done  output  1  image accepted, CPU running
boot_error  output  1  frame rejected
words_loaded  output  ADDR_W+1  count of words written in the current frame

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All state updates on posedge clk.
- Reset values:
  - imem_we=0, imem_addr=0, imem_wdata=0, words_loaded=0
  - cpu_hold=1, boot_done=0, boot_error=0
  - state=IDLE
- Frame format: SYNC, LEN_LO, LEN_HI, then 4*LEN payload bytes, then CSUM.
  - LEN is the number of words.
  - Each word is sent little-endian: byte 0 goes to [7:0], byte 3 goes to [31:24].
  - CSUM is the sum mod 256 of all payload bytes.
- Bytes are acted on only in a cycle with rx_valid=1.
- States:
  - IDLE: byte == SYNC -> LEN_LO. Any other byte is ignored.
  - LEN_LO: latch len[7:0] -> LEN_HI.
  - LEN_HI: latch len[15:8].
    - len > IMEM_WORDS -> ERROR.
    - len == 0 -> CSUM.
    - otherwise -> DATA.
    - Clear words_loaded, the byte index, the address and the running checksum.
  - DATA: shift the byte into its lane and add it to the checksum.
    - On the 4th byte of a word, imem_we pulses high for exactly one cycle in the next cycle. In that cycle imem_addr holds the word index and imem_wdata holds the assembled word.
    - words_loaded increments in that same cycle.
    - After the last word -> CSUM.
  - CSUM:
    - byte == checksum -> DONE.
    - otherwise -> ERROR. Words already written are not erased.
  - DONE: cpu_hold=0, boot_done=1. All further bytes, including SYNC, are ignored until rst.
  - ERROR: boot_error=1, cpu_hold=1.
    - A byte equal to SYNC clears boot_error and -> LEN_LO (a retry).
    - Other bytes are ignored.
- Timeout:
  - In LEN_LO, LEN_HI, DATA and CSUM, a counter clears on each rx_valid and increments otherwise.
  - When it reaches TIMEOUT_CYCLES -> ERROR.
  - The counter is inactive in IDLE, DONE and ERROR.
- imem_we never asserts outside DATA. The write address never exceeds IMEM_WORDS-1.
- rx_valid in the same cycle as an imem_we pulse: the byte is still accepted. Minimum rx_valid spacing is 1 clock.
- rst asserted mid-frame: abandon immediately and apply reset values. The next clock starts in IDLE.
- cpu_hold stays asserted through every state except DONE. It deasserts on the clock edge that enters DONE.

Test Plan:
- Good image: A5 02 00 | 13 00 00 00 | 93 00 10 00 | B6 -> two imem_we pulses, (addr 0, 0x00000013) then (addr 1, 0x00100093); words_loaded=2; boot_done=1, cpu_hold=0 one cycle after the CSUM byte.
- Bad checksum then retry: A5 01 00 | 01 02 03 04 | 00 -> boot_error=1, cpu_hold=1, one write already done; then A5 01 00 | 01 02 03 04 | 0A -> boot_error=0, boot_done=1.
- Oversize length: A5 01 01 (LEN=257 with IMEM_WORDS=256) -> ERROR right after LEN_HI; zero imem_we pulses.
- Zero length with noise: bytes 00 FF before the frame, then A5 00 00 00 -> noise ignored in IDLE; boot_done=1; no writes.
- Timeout: TIMEOUT_CYCLES=50; send A5 01 00 11, then idle 50 clocks -> boot_error=1; no write issued.
- Reset mid-frame, then post-DONE bytes:
  - rst pulsed after 2 payload bytes -> all outputs at reset values, state IDLE; a full good frame afterwards succeeds.
  - Bytes sent after DONE cause no writes.
